// File: rtl/mmio_dmem.sv
// Data RAM plus memory-mapped LED, switch and compare-match timer registers
// for the MIPS memory stage; loads are combinational, stores land on the clock edge.
module mmio_dmem #(
    parameter int RAM_WORDS = 64,
    parameter int SW_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwriteM,
    input  logic [31:0]     aluoutM,
    input  logic [31:0]     writedataM,
    output logic [31:0]     readdataM,
    input  logic [SW_W-1:0] switches,
    output logic [SW_W-1:0] leds,
    output logic            irq
);
    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    // Word addresses (byte address >> 2) of the peripheral registers
    localparam logic [29:0] A_LED  = 30'h3FFF_FFC0;
    localparam logic [29:0] A_SW   = 30'h3FFF_FFC1;
    localparam logic [29:0] A_CNT  = 30'h3FFF_FFC2;
    localparam logic [29:0] A_CMP  = 30'h3FFF_FFC3;
    localparam logic [29:0] A_CTRL = 30'h3FFF_FFC4;

    logic [31:0]     mem_q [RAM_WORDS];
    logic [SW_W-1:0] leds_q, leds_d;
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     cmp_q, cmp_d;
    logic            en_q, en_d, ar_q, ar_d, ie_q, ie_d, flag_q, flag_d;

    logic [29:0]   word;
    logic          ram_hit, match;
    logic [AW-1:0] ram_idx;
    logic          wr_led, wr_cnt, wr_cmp, wr_ctrl;
    logic          unused_lsb;

    assign word       = aluoutM[31:2];
    assign unused_lsb = ^aluoutM[1:0];
    assign ram_hit    = (aluoutM[31:AW+2] == '0);
    assign ram_idx    = aluoutM[AW+1:2];
    assign wr_led     = memwriteM && (word == A_LED);
    assign wr_cnt     = memwriteM && (word == A_CNT);
    assign wr_cmp     = memwriteM && (word == A_CMP);
    assign wr_ctrl    = memwriteM && (word == A_CTRL);
    assign match      = en_q && (cnt_q == cmp_q);

    always_comb begin
        leds_d = wr_led ? writedataM[SW_W-1:0] : leds_q;
        cmp_d  = wr_cmp ? writedataM : cmp_q;
        en_d   = wr_ctrl ? writedataM[0] : en_q;
        ar_d   = wr_ctrl ? writedataM[1] : ar_q;
        ie_d   = wr_ctrl ? writedataM[3] : ie_q;

        // A CPU load of CNT beats both increment and autoreload
        cnt_d = cnt_q;
        if (wr_cnt)
            cnt_d = writedataM;
        else if (en_q)
            cnt_d = (match && ar_q) ? 32'd0 : cnt_q + 32'd1;

        // Hardware set wins over a coincident W1C
        flag_d = flag_q;
        if (wr_ctrl && writedataM[2])
            flag_d = 1'b0;
        if (match)
            flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q  <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            cnt_q   <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            leds_q  <= leds_d;
            sw_s1_q <= switches;
            sw_s2_q <= sw_s1_q;
            cnt_q   <= cnt_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            flag_q  <= flag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && memwriteM && ram_hit)
            mem_q[ram_idx] <= writedataM;
    end

    always_comb begin
        readdataM = '0;
        if (ram_hit) begin
            readdataM = mem_q[ram_idx];
        end else begin
            case (word)
                A_LED:   readdataM[SW_W-1:0] = leds_q;
                A_SW:    readdataM[SW_W-1:0] = sw_s2_q;
                A_CNT:   readdataM = cnt_q;
                A_CMP:   readdataM = cmp_q;
                A_CTRL:  readdataM[3:0] = {ie_q, flag_q, ar_q, en_q};
                default: readdataM = '0;
            endcase
        end
    end

    assign leds = leds_q;
    assign irq  = flag_q & ie_q;

endmodule
